// File: rtl/sprite_pkg.sv
// sprite_pkg: shared index width, palette colours, transparency index and writer FSM states
package sprite_pkg;
   localparam int IDX_W = 2;
   localparam logic [23:0] PAL_BLACK = 24'h000000;
   localparam logic [23:0] PAL_WHITE = 24'hFFFFFF;
   localparam logic [IDX_W-1:0] IDX_TRANSPARENT = 2'd2;
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
   function automatic logic [23:0] pal_rgb(input logic [IDX_W-1:0] idx);
      return (idx == 2'd1) ? PAL_WHITE : PAL_BLACK;
   endfunction
endpackage

// File: rtl/sprite_ram_writer_if.sv
// sprite_ram_writer_if: valid/ready pixel stream from the sprite loader into the writer
interface sprite_ram_writer_if;
   logic pix_valid;
   logic [23:0] pix_rgb;
   logic pix_ready;
   modport master(output pix_valid, pix_rgb, input pix_ready);
   modport slave(input pix_valid, pix_rgb, output pix_ready);
endinterface

// File: rtl/sprite_color_encoder.sv
// sprite_color_encoder: RGB -> palette index plus hit flag; chroma key honoured when SPRITE_WR_CHROMA_EN is defined
module sprite_color_encoder
   import sprite_pkg::*;
#(
   parameter logic [23:0] KEY_RGB = 24'hFF00FF
) (
   input  logic [23:0]      rgb,
   output logic [IDX_W-1:0] idx,
   output logic             hit
);
`ifdef SPRITE_WR_CHROMA_EN
   localparam bit CHROMA = 1'b1;
`else
   localparam bit CHROMA = 1'b0;
`endif
   logic is_key;
   assign is_key = CHROMA && (rgb == KEY_RGB);
   assign idx = (rgb == PAL_WHITE) ? 2'd1 : is_key ? IDX_TRANSPARENT : 2'd0;
   assign hit = (rgb == PAL_BLACK) || (rgb == PAL_WHITE) || is_key;
endmodule

// File: rtl/sprite_ram_writer.sv
// sprite_ram_writer: streams RGB pixels into palette-indexed sprite RAM with a registered RGB read port; SPRITE_WR_CHROMA_EN enables chroma-key transparency
module sprite_ram_writer
   import sprite_pkg::*;
#(
   parameter int          DEPTH   = 256,
   parameter int          ADDR_W  = 19,
   parameter logic [23:0] KEY_RGB = 24'hFF00FF
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [8:0]        length,
   sprite_ram_writer_if.slave pix,
   output logic              busy,
   output logic              done,
   output logic              err_unmapped,
   output logic [8:0]        words_written,
   input  logic [ADDR_W-1:0] read_address,
   output logic [23:0]       data_Out,
   output logic              data_Transparent
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_LOAD = LOAD;
   localparam logic [1:0] ST_DONE = DONE;
   logic [1:0] state, nxt;
   logic [AW-1:0] cursor;
   logic [8:0] len;
   logic [IDX_W-1:0] enc_idx, rd_idx;
   logic enc_hit, accept, last;
   logic [IDX_W-1:0] mem [DEPTH];
   sprite_color_encoder #(.KEY_RGB(KEY_RGB)) u_enc (.rgb(pix.pix_rgb), .idx(enc_idx), .hit(enc_hit));
   assign accept = pix.pix_valid && pix.pix_ready;
   assign last = accept && (words_written + 9'd1 == len);
   assign busy = (state == ST_LOAD);
   assign done = (state == ST_DONE);
   assign rd_idx = mem[AW'(read_address % ADDR_W'(DEPTH))];
   // next state: zero-length loads skip straight to DONE
   always_comb
      nxt = (state == ST_IDLE) ? (start ? ((length != 9'd0) ? ST_LOAD : ST_DONE) : ST_IDLE) :
            (state == ST_LOAD) ? (last ? ST_DONE : ST_LOAD) : ST_IDLE;
   // FSM, write cursor, pixel counter and sticky unmapped flag
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         state <= ST_IDLE;
         pix.pix_ready <= 1'b0;
         cursor <= '0;
         len <= '0;
         words_written <= '0;
         err_unmapped <= 1'b0;
      end else begin
         state <= nxt;
         pix.pix_ready <= (nxt == ST_LOAD);
         if (state == ST_IDLE && start) begin
            cursor <= AW'(base_addr % ADDR_W'(DEPTH));
            len <= length;
            words_written <= '0;
            err_unmapped <= 1'b0;
         end else if (accept) begin
            cursor <= (cursor == AW'(DEPTH - 1)) ? '0 : cursor + 1'b1;
            words_written <= words_written + 9'd1;
            if (!enc_hit) err_unmapped <= 1'b1;
         end
      end
   // sprite RAM write port; contents deliberately survive reset
   always_ff @(posedge Clk)
      if (accept) mem[cursor] <= enc_idx;
   // palette lookup register; a same-address write lands after this read, so old data is returned
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) data_Out <= '0;
      else data_Out <= pal_rgb(rd_idx);
`ifdef SPRITE_WR_CHROMA_EN
   // transparency flag travels alongside the colour with the same latency
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) data_Transparent <= 1'b0;
      else data_Transparent <= (rd_idx == IDX_TRANSPARENT);
`else
   assign data_Transparent = 1'b0;
`endif
endmodule

// File: tb/tb_sprite_ram_writer.sv
// tb_sprite_ram_writer: randomized self-checking bench for sprite_ram_writer against a colour-level memory model
module tb_sprite_ram_writer;
   localparam int DEPTH = 256;
`ifdef SPRITE_WR_CHROMA_EN
   localparam bit CH = 1'b1;
`else
   localparam bit CH = 1'b0;
`endif
   logic Clk = 1'b0, Reset_n = 1'b0, start = 1'b0;
   logic [18:0] base_addr = '0, read_address = '0;
   logic [8:0] length = '0, words_written;
   logic busy, done, err_unmapped, data_Transparent;
   logic [23:0] data_Out;
   int n_checks = 0, n_fail = 0;
   logic [23:0] shadow [DEPTH];
   bit exp_err;
   int exp_words;
   sprite_ram_writer_if intf();
   sprite_ram_writer dut (
      .Clk(Clk), .Reset_n(Reset_n), .start(start), .base_addr(base_addr), .length(length),
      .pix(intf), .busy(busy), .done(done), .err_unmapped(err_unmapped),
      .words_written(words_written), .read_address(read_address),
      .data_Out(data_Out), .data_Transparent(data_Transparent)
   );
   always #5 Clk = ~Clk;

   function automatic logic [23:0] exp_rgb(input logic [23:0] c);
      return (c == 24'hFFFFFF) ? 24'hFFFFFF : 24'h000000;
   endfunction
   function automatic bit bad(input logic [23:0] c);
      return !(c == 24'h000000 || c == 24'hFFFFFF || (CH && c == 24'hFF00FF));
   endfunction
   function automatic bit exp_tr(input logic [23:0] c);
      return CH && c == 24'hFF00FF;
   endfunction
   function automatic logic [23:0] rnd_px();
      int k = $urandom_range(0, 5);
      return (k < 2) ? 24'h000000 : (k < 4) ? 24'hFFFFFF : (k == 4) ? 24'hFF00FF : 24'($urandom);
   endfunction

   // start a load at a negedge and stream px; the model records every accepted pixel
   task automatic load(input int base, input logic [23:0] px[$], input bit stall, input bit restart,
                       output bit done_seen, output bit done_next, output bit busy_ok, output bit timeout);
      int n = px.size();
      int i = 0;
      int guard = 0;
      bit v;
      start = 1'b1; base_addr = 19'(base); length = 9'(n);
      @(negedge Clk);
      start = 1'b0; exp_err = 1'b0; busy_ok = 1'b1;
      while (i < n && guard < 1000) begin
         if (!busy) busy_ok = 1'b0;
         v = stall ? (guard % 2 == 0) : 1'b1;
         if (restart && guard == 1) begin start = 1'b1; base_addr = 19'(base + 77); length = 9'd1; end
         intf.pix_valid = v; intf.pix_rgb = px[i];
         if (v && intf.pix_ready) begin
            shadow[(base + i) % DEPTH] = px[i];
            exp_err |= bad(px[i]);
            i++;
         end
         @(negedge Clk);
         start = 1'b0; guard++;
      end
      intf.pix_valid = 1'b0;
      timeout = (i < n);
      exp_words = i;
      done_seen = done;
      @(negedge Clk);
      done_next = done;
   endtask

   task automatic rd(input int a, output logic [23:0] rgb, output logic tr);
      read_address = 19'(a % DEPTH + DEPTH * $urandom_range(0, 2047));
      @(negedge Clk);
      rgb = data_Out; tr = data_Transparent;
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      repeat (2) @(negedge Clk);
      n_checks++; if ({intf.pix_ready, busy, done, err_unmapped} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {intf.pix_ready, busy, done, err_unmapped}); end
      n_checks++; if (words_written !== 9'd0) begin n_fail++; $display("FAIL reset_words: got %0d want 0", words_written); end
      n_checks++; if ({data_Out, data_Transparent} !== 25'd0) begin n_fail++; $display("FAIL reset_read: got %h/%b want 0/0", data_Out, data_Transparent); end
      Reset_n = 1'b1;
      @(negedge Clk);
   endtask

   task automatic test_reset_mid_load();
      logic [23:0] px[$];
      logic [23:0] got;
      logic tr;
      bit ds, dn, bo, to;
      px = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF};
      start = 1'b1; base_addr = '0; length = 9'd8;
      @(negedge Clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         intf.pix_valid = 1'b1; intf.pix_rgb = px[i]; shadow[i] = px[i];
         @(negedge Clk);
      end
      intf.pix_valid = 1'b0;
      n_checks++; if (words_written !== 9'd3) begin n_fail++; $display("FAIL midload_words: got %0d want 3", words_written); end
      #2 Reset_n = 1'b0;
      #1;
      n_checks++; if ({intf.pix_ready, busy, done, err_unmapped, words_written} !== 13'd0) begin n_fail++; $display("FAIL midload_reset: got %b want 0", {intf.pix_ready, busy, done, err_unmapped, words_written}); end
      n_checks++; if ({data_Out, data_Transparent} !== 25'd0) begin n_fail++; $display("FAIL midload_reset_read: got %h want 0", data_Out); end
      @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
      for (int a = 0; a < 3; a++) begin
         rd(a, got, tr);
         n_checks++; if (got !== exp_rgb(shadow[a])) begin n_fail++; $display("FAIL retain_%0d: got %h want %h", a, got, exp_rgb(shadow[a])); end
      end
      px = '{24'h000000, 24'hFFFFFF};
      load(0, px, 1'b0, 1'b0, ds, dn, bo, to);
      n_checks++; if ({ds, dn, to} !== 3'b100) begin n_fail++; $display("FAIL restart_done: got %b want 100", {ds, dn, to}); end
      for (int a = 0; a < 3; a++) begin
         rd(a, got, tr);
         n_checks++; if (got !== exp_rgb(shadow[a])) begin n_fail++; $display("FAIL restart_read_%0d: got %h want %h", a, got, exp_rgb(shadow[a])); end
      end
   endtask

   task automatic test_basic_load();
      logic [23:0] px[$];
      logic [23:0] got;
      logic tr;
      bit ds, dn, bo, to;
      px = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'hFFFFFF};
      load(0, px, 1'b0, 1'b0, ds, dn, bo, to);
      n_checks++; if ({ds, dn, bo, to} !== 4'b1010) begin n_fail++; $display("FAIL basic_handshake: got %b want 1010", {ds, dn, bo, to}); end
      n_checks++; if (words_written !== 9'd4) begin n_fail++; $display("FAIL basic_words: got %0d want 4", words_written); end
      n_checks++; if (err_unmapped !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", err_unmapped); end
      for (int a = 0; a < 4; a++) begin
         rd(a, got, tr);
         n_checks++; if (got !== px[a]) begin n_fail++; $display("FAIL basic_read_%0d: got %h want %h", a, got, px[a]); end
      end
   endtask

   task automatic test_wrap_stalls();
      logic [23:0] px[$];
      logic [23:0] got;
      logic tr;
      bit ds, dn, bo, to;
      px = '{24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'h000000};
      shadow[2] = 24'hFFFFFF;
      load(2, '{24'hFFFFFF}, 1'b0, 1'b0, ds, dn, bo, to);
      load(254, px, 1'b1, 1'b0, ds, dn, bo, to);
      n_checks++; if ({ds, bo, to} !== 3'b110) begin n_fail++; $display("FAIL wrap_busy: got %b want 110", {ds, bo, to}); end
      n_checks++; if (words_written !== 9'd4) begin n_fail++; $display("FAIL wrap_words: got %0d want 4", words_written); end
      for (int k = 0; k < 5; k++) begin
         int a = (254 + k) % DEPTH;
         rd(a, got, tr);
         n_checks++; if (got !== exp_rgb(shadow[a])) begin n_fail++; $display("FAIL wrap_read_%0d: got %h want %h", a, got, exp_rgb(shadow[a])); end
      end
   endtask

   task automatic test_unmapped();
      logic [23:0] got;
      logic tr;
      bit ds, dn, bo, to;
      load(10, '{24'h123456}, 1'b0, 1'b0, ds, dn, bo, to);
      repeat (3) @(negedge Clk);
      n_checks++; if (err_unmapped !== 1'b1) begin n_fail++; $display("FAIL unmapped_err: got %b want 1", err_unmapped); end
      rd(10, got, tr);
      n_checks++; if (got !== 24'h0) begin n_fail++; $display("FAIL unmapped_read: got %h want 000000", got); end
      load(11, '{24'hFFFFFF}, 1'b0, 1'b0, ds, dn, bo, to);
      n_checks++; if (err_unmapped !== 1'b0) begin n_fail++; $display("FAIL unmapped_clear: got %b want 0", err_unmapped); end
   endtask

   task automatic test_chroma();
      logic [23:0] got;
      logic tr;
      bit ds, dn, bo, to;
      load(5, '{24'hFF00FF}, 1'b0, 1'b0, ds, dn, bo, to);
      n_checks++; if (err_unmapped !== !CH) begin n_fail++; $display("FAIL chroma_err: got %b want %b", err_unmapped, !CH); end
      rd(5, got, tr);
      n_checks++; if ({got, tr} !== {24'h0, CH}) begin n_fail++; $display("FAIL chroma_read: got %h/%b want 000000/%b", got, tr, CH); end
   endtask

   task automatic test_len_zero();
      logic [23:0] got;
      logic tr;
      shadow[20] = 24'hFFFFFF;
      load(20, '{24'hFFFFFF}, 1'b0, 1'b0, got[0], got[1], got[2], got[3]);
      start = 1'b1; base_addr = 19'd20; length = 9'd0; intf.pix_valid = 1'b1; intf.pix_rgb = 24'h000000;
      @(negedge Clk);
      start = 1'b0;
      n_checks++; if ({done, busy, intf.pix_ready} !== 3'b100) begin n_fail++; $display("FAIL len0_done: got %b want 100", {done, busy, intf.pix_ready}); end
      @(negedge Clk);
      intf.pix_valid = 1'b0;
      n_checks++; if ({done, words_written} !== 10'd0) begin n_fail++; $display("FAIL len0_after: got %b want 0", {done, words_written}); end
      rd(20, got, tr);
      n_checks++; if (got !== 24'hFFFFFF) begin n_fail++; $display("FAIL len0_nowrite: got %h want FFFFFF", got); end
   endtask

   task automatic test_start_during_load();
      logic [23:0] px[$];
      logic [23:0] got;
      logic tr;
      bit ds, dn, bo, to;
      shadow[107] = 24'hFFFFFF;
      load(107, '{24'hFFFFFF}, 1'b0, 1'b0, ds, dn, bo, to);
      px = '{24'h000000, 24'hFFFFFF, 24'h000000};
      load(30, px, 1'b0, 1'b1, ds, dn, bo, to);
      n_checks++; if ({words_written, ds, to} !== {9'd3, 2'b10}) begin n_fail++; $display("FAIL restart_ignored: got %0d/%b/%b want 3/1/0", words_written, ds, to); end
      rd(107, got, tr);
      n_checks++; if (got !== 24'hFFFFFF) begin n_fail++; $display("FAIL restart_target: got %h want FFFFFF", got); end
      rd(31, got, tr);
      n_checks++; if (got !== 24'hFFFFFF) begin n_fail++; $display("FAIL restart_data: got %h want FFFFFF", got); end
   endtask

   task automatic test_rw_collision();
      bit ds, dn, bo, to;
      load(40, '{24'hFFFFFF}, 1'b0, 1'b0, ds, dn, bo, to);
      read_address = 19'd40;
      start = 1'b1; base_addr = 19'd40; length = 9'd1;
      @(negedge Clk);
      start = 1'b0; intf.pix_valid = 1'b1; intf.pix_rgb = 24'h000000; shadow[40] = 24'h000000;
      @(negedge Clk);
      intf.pix_valid = 1'b0;
      n_checks++; if (data_Out !== 24'hFFFFFF) begin n_fail++; $display("FAIL collide_old: got %h want FFFFFF", data_Out); end
      @(negedge Clk);
      n_checks++; if (data_Out !== 24'h000000) begin n_fail++; $display("FAIL collide_new: got %h want 000000", data_Out); end
   endtask

   task automatic test_random_loads();
      logic [23:0] px[$];
      logic [23:0] got;
      logic tr;
      bit ds, dn, bo, to;
      for (int it = 0; it < 8; it++) begin
         int base = $urandom_range(0, 524287);
         int n = $urandom_range(1, 20);
         px = {};
         for (int k = 0; k < n; k++) px.push_back(rnd_px());
         load(base, px, 1'($urandom_range(0, 1)), 1'b0, ds, dn, bo, to);
         n_checks++; if ({ds, dn, bo, to} !== 4'b1010) begin n_fail++; $display("FAIL rnd%0d_handshake: got %b want 1010", it, {ds, dn, bo, to}); end
         n_checks++; if ({words_written, err_unmapped} !== {9'(exp_words), exp_err}) begin n_fail++; $display("FAIL rnd%0d_status: got %0d/%b want %0d/%b", it, words_written, err_unmapped, exp_words, exp_err); end
         for (int k = 0; k < n; k++) begin
            int a = (base + k) % DEPTH;
            rd(a, got, tr);
            n_checks++; if ({got, tr} !== {exp_rgb(shadow[a]), exp_tr(shadow[a])}) begin n_fail++; $display("FAIL rnd%0d_read_%0d: got %h/%b want %h/%b", it, a, got, tr, exp_rgb(shadow[a]), exp_tr(shadow[a])); end
         end
      end
   endtask

   initial begin
      intf.pix_valid = 1'b0;
      intf.pix_rgb = '0;
      foreach (shadow[i]) shadow[i] = '0;
      @(negedge Clk);
      test_reset();
      test_reset_mid_load();
      test_basic_load();
      test_wrap_stalls();
      test_unmapped();
      test_chroma();
      test_len_zero();
      test_start_during_load();
      test_rw_collision();
      test_random_loads();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
